// File: rtl/mii_fcs_appender_if.sv
// Nibble stream from the user-data inserter plus the MII transmit pins and frame status.
interface mii_fcs_appender_if;
    logic [3:0] with_usr;
    logic       with_usr_valid;
    logic       ready;
    logic [3:0] mii_txd;
    logic       mii_tx_en;
    logic       frame_done;
    logic       frame_err;

    modport master (
        output with_usr, with_usr_valid,
        input  ready, mii_txd, mii_tx_en, frame_done, frame_err
    );

    modport slave (
        input  with_usr, with_usr_valid,
        output ready, mii_txd, mii_tx_en, frame_done, frame_err
    );
endinterface

// File: rtl/mii_fcs_appender.sv
// Final MII TX stage: one-cycle pass-through, CRC-32 over post-SFD nibbles,
// zero padding to a minimum length, FCS append and inter-frame gap.
module mii_fcs_appender #(
    parameter int MIN_DATA_NIBBLES = 120,
    parameter int IFG_NIBBLES      = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    mii_fcs_appender_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [10:0] MIN_CNT  = 11'(MIN_DATA_NIBBLES);
    localparam logic [10:0] IFG_CNT  = 11'(IFG_NIBBLES);

    state_t      r_state, w_state_next;
    logic [31:0] r_crc, w_crc_next;
    logic [10:0] r_cnt, w_cnt_next;
    logic [2:0]  r_fcs_idx, w_fcs_idx_next;
    logic        r_valid_d;
    logic [3:0]  r_txd, w_txd_next;
    logic        r_tx_en, w_tx_en_next;
    logic        r_done, w_done_next;
    logic        r_err, w_err_next;

    logic        w_rise;
    logic [3:0]  w_crc_din;
    logic [31:0] w_crc_chain [0:4];
    logic [31:0] w_fcs_all;
    logic [3:0]  w_fcs_nib;
    logic [11:0] w_pad_diff;
    logic        w_need_pad;

    // Frames start only on a rising valid; a tail still high after reset never qualifies.
    assign w_rise    = bus.with_usr_valid & ~r_valid_d;
    assign w_crc_din = (r_state == S_DATA && bus.with_usr_valid) ? bus.with_usr : 4'h0;

    assign w_crc_chain[0] = r_crc;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_crc
            assign w_crc_chain[gi+1] = (w_crc_chain[gi] >> 1) ^
                ((w_crc_chain[gi][0] ^ w_crc_din[gi]) ? CRC_POLY : 32'h0);
        end
    endgenerate

    assign w_fcs_all  = ~r_crc;
    assign w_fcs_nib  = w_fcs_all[{r_fcs_idx, 2'b00} +: 4];
    assign w_pad_diff = {1'b0, r_cnt} - {1'b0, MIN_CNT};
    assign w_need_pad = w_pad_diff[11];

    always_comb begin
        w_state_next   = r_state;
        w_crc_next     = r_crc;
        w_cnt_next     = r_cnt;
        w_fcs_idx_next = r_fcs_idx;
        w_txd_next     = 4'h0;
        w_tx_en_next   = 1'b0;
        w_done_next    = 1'b0;
        w_err_next     = w_rise && (r_state == S_PAD || r_state == S_FCS || r_state == S_IFG);
        case (r_state)
            S_IDLE: begin
                w_crc_next     = CRC_INIT;
                w_cnt_next     = '0;
                w_fcs_idx_next = '0;
                if (w_rise) begin
                    w_state_next = S_PRE;
                    w_txd_next   = bus.with_usr;
                    w_tx_en_next = 1'b1;
                end
            end
            S_PRE: begin
                if (bus.with_usr_valid) begin
                    w_txd_next   = bus.with_usr;
                    w_tx_en_next = 1'b1;
                    if (bus.with_usr == 4'hD) begin
                        w_state_next = S_DATA;
                        w_crc_next   = CRC_INIT;
                        w_cnt_next   = '0;
                    end
                end else begin
                    // tx_en drops this edge, so the gap count starts one ahead.
                    w_err_next   = 1'b1;
                    w_state_next = S_IFG;
                    w_cnt_next   = 11'd1;
                end
            end
            S_DATA, S_PAD: begin
                w_tx_en_next = 1'b1;
                if (r_state == S_DATA && bus.with_usr_valid) begin
                    w_txd_next = bus.with_usr;
                    w_crc_next = w_crc_chain[4];
                    if (r_cnt != 11'h7FF)
                        w_cnt_next = r_cnt + 11'd1;
                end else if (w_need_pad) begin
                    w_state_next = S_PAD;
                    w_crc_next   = w_crc_chain[4];
                    w_cnt_next   = r_cnt + 11'd1;
                end else begin
                    w_state_next   = S_FCS;
                    w_txd_next     = w_fcs_nib;
                    w_fcs_idx_next = 3'd1;
                end
            end
            S_FCS: begin
                w_tx_en_next   = 1'b1;
                w_txd_next     = w_fcs_nib;
                w_fcs_idx_next = r_fcs_idx + 3'd1;
                if (r_fcs_idx == 3'd7) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IFG;
                    w_cnt_next   = '0;
                end
            end
            S_IFG: begin
                if (r_cnt >= IFG_CNT) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 11'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_crc     <= CRC_INIT;
            r_cnt     <= '0;
            r_fcs_idx <= '0;
            r_valid_d <= 1'b1;
            r_txd     <= 4'h0;
            r_tx_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_crc     <= w_crc_next;
            r_cnt     <= w_cnt_next;
            r_fcs_idx <= w_fcs_idx_next;
            r_valid_d <= bus.with_usr_valid;
            r_txd     <= w_txd_next;
            r_tx_en   <= w_tx_en_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    assign bus.ready      = (r_state == S_IDLE);
    assign bus.mii_txd    = r_txd;
    assign bus.mii_tx_en  = r_tx_en;
    assign bus.frame_done = r_done;
    assign bus.frame_err  = r_err;
endmodule

// File: doc/mii_fcs_appender.md
# mii_fcs_appender

Final MII transmit stage: consumes the preamble-prefixed nibble stream from the user-data inserter and drives the PHY's MII transmit pins. Passes each nibble through with one cycle of latency. Computes the Ethernet CRC-32 over every nibble after the SFD, zero-pads short frames to the minimum length, and appends the 8-nibble FCS. It then holds `mii_tx_en` low for the inter-frame gap and signals readiness for the next frame.

## Interface
- `MIN_DATA_NIBBLES`, 120 — minimum post-SFD nibble count before FCS (60 bytes); 0 disables padding
- `IFG_NIBBLES`, 24 — idle nibble-times after last FCS nibble (96 bit times)
- `clk`  in  1  MII TX clock (25 MHz); all logic on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `with_usr`  in  4  input nibble (LSB-first nibble order, low nibble of each byte first)
- `with_usr_valid`  in  1  high for each nibble of a frame; contiguous from first preamble nibble to last data nibble
- `ready`  out  1  high when idle and IFG satisfied; upstream starts a frame only while high
- `mii_txd`  out  4  MII TXD
- `mii_tx_en`  out  1  MII TX_EN
- `frame_done`  out  1  one-cycle pulse, same cycle as last FCS nibble on `mii_txd`
- `frame_err`  out  1  one-cycle pulse on dropped or aborted frame

## Operation
- Reset values: `mii_txd`=0, `mii_tx_en`=0, `ready`=1, `frame_done`=0, `frame_err`=0, state IDLE, CRC=0xFFFFFFFF, counters 0.
- States:
  - IDLE -> PRE on `with_usr_valid`=1; that nibble is transmitted.
  - PRE: pass nibbles. A nibble equal to 0xD moves to DATA and sets CRC=0xFFFFFFFF; the SFD itself is excluded from the CRC. If valid falls in PRE, pulse `frame_err` and go to IFG with no FCS.
  - DATA: pass nibbles, update CRC, increment data counter. The counter is 11 bits and saturates at 2047. When valid falls: go to PAD if counter < `MIN_DATA_NIBBLES`, else go to FCS.
  - PAD: emit 0x0 nibbles into the CRC and counter until counter = `MIN_DATA_NIBBLES`, then go to FCS.
  - FCS: emit nibble k = (~crc)[4k+3:4k], k = 0..7, in order. No CRC update. After k=7, go to IFG.
  - IFG: `mii_tx_en`=0 for `IFG_NIBBLES` cycles, then go to IDLE.
- CRC update: nibble-serial, reflected polynomial 0xEDB88320. Process the 4 nibble bits LSB first: for each bit, c = (c>>1) ^ (((c[0]^d[i])) ? 0xEDB88320 : 0).
- `ready` = (state == IDLE).
- Any `with_usr_valid` rising edge while not IDLE (PAD, FCS, IFG): the frame is ignored entirely, never transmitted. Pulse `frame_err` once, in the cycle after the rising edge. Ignoring persists until valid falls, even if IDLE is reached mid-frame.
- `rst_n` asserted mid-frame: outputs return to reset values immediately (asynchronous), with no FCS. After release, the block is IDLE; if valid is still high it is treated as a mid-frame tail and ignored until valid falls, with no `frame_err`.

## Timing
- Pass-through latency: input nibble at cycle n appears on `mii_txd` with `mii_tx_en`=1 at cycle n+1.
- Last valid input at cycle L: that nibble appears at L+1. The first pad or FCS nibble appears at L+2. There is no gap in `mii_tx_en` between data, pad and FCS.
- Without padding, FCS occupies L+2..L+9. `mii_tx_en` falls at L+10, and `ready` rises at L+10+`IFG_NIBBLES`.
- With padding of P nibbles, the FCS shifts later by P cycles.
- `mii_txd`=0 whenever `mii_tx_en`=0.
- A frame whose valid asserts in the first cycle `ready` is high is accepted.

## Test plan
- `MIN_DATA_NIBBLES`=0. Send 15×0x5, 0xD, then bytes "123456789" (0x31..0x39, low nibble first, 18 nibbles) -> output matches input delayed 1 cycle, followed by FCS nibbles 6,2,9,3,4,F,B,C. `frame_done` is high with nibble C; `mii_tx_en` drops the next cycle.
- Default params. Send preamble + SFD + 10 data nibbles -> 110 zero nibbles follow, then 8 FCS nibbles equal to the reference-model CRC over 120 nibbles. Total `mii_tx_en` high = 16+120+8 cycles.
- Back-to-back frames, upstream obeys `ready` -> `mii_tx_en` low exactly 24 cycles between frames; `ready` rises exactly 24 cycles after `mii_tx_en` falls.
- Frame started during IFG (valid asserted 5 cycles after `mii_tx_en` falls) -> nothing transmitted, `frame_err` pulses once. The next frame, started when `ready` is high, is transmitted normally.
- Valid drops after 8 preamble nibbles (no SFD) -> 8 nibbles transmitted, no FCS, `frame_err` pulse, then IFG of 24 cycles before `ready`.
- `rst_n` low for 3 cycles in the middle of DATA while valid stays high -> `mii_tx_en` goes 0 asynchronously and `ready`=1. The remainder of the frame is ignored, with no `frame_err`. The next frame is transmitted with a correct FCS.
